// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Pure declarations: no latency, no flow control.
package bus_arb_pkg;

    localparam int ARB_STATE_W = 2;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_TURN  = 2'd2
    } arb_state_t;

    // Index width for a count of n items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at or above ptr, wrapping.
// Zero latency; no backpressure (pure function of its inputs).
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int cand;

    // Scanning from the far end down lets the candidate nearest ptr win last.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (req[cand]) begin
                idx = IW'(cand);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of a shared tri-state bus with bounded tenure and a one-cycle turnaround.
// Grant 1 cycle after request; data registered 1 cycle after each transfer; a dropped req releases the bus.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int N        = 16,
    parameter  int MAX_HOLD = 8,
    localparam int IW       = idx_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] din,
    output logic [NREQ-1:0]   gnt,
    output logic [IW-1:0]     sel,
    output logic              bus_en,
    output logic [N-1:0]      dout,
    output logic              dout_valid
);

    localparam int HW = idx_width(MAX_HOLD);

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   sel_q, sel_d;
    logic            bus_en_q, bus_en_d;
    logic [N-1:0]    dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;

    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [N-1:0]    owner_dat;
    logic [IW-1:0]   next_ptr;
    logic            last_xfer;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign owner_dat = din[int'(sel_q)*N +: N];
    assign next_ptr  = (sel_q == IW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
    assign last_xfer = (hold_cnt_q == HW'(MAX_HOLD - 1));

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        sel_d        = sel_q;
        bus_en_d     = bus_en_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        rr_ptr_d     = rr_ptr_q;
        hold_cnt_d   = hold_cnt_q;

        unique case (state_q)
            ARB_IDLE, ARB_TURN: begin
                gnt_d    = '0;
                bus_en_d = 1'b0;
                state_d  = ARB_IDLE;
                if (pick_any) begin
                    state_d         = ARB_GRANT;
                    gnt_d[pick_idx] = 1'b1;
                    sel_d           = pick_idx;
                    bus_en_d        = 1'b1;
                    hold_cnt_d      = '0;
                end
            end
            ARB_GRANT: begin
                if (req[sel_q]) begin
                    dout_d       = owner_dat;
                    dout_valid_d = 1'b1;
                    hold_cnt_d   = hold_cnt_q + 1'b1;
                end
                // Tenure ends on the last allowed transfer or when the owner lets go.
                if (!req[sel_q] || last_xfer) begin
                    state_d  = ARB_TURN;
                    gnt_d    = '0;
                    bus_en_d = 1'b0;
                    rr_ptr_d = next_ptr;
                end
            end
            default: begin
                state_d  = ARB_IDLE;
                gnt_d    = '0;
                bus_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            gnt_q        <= '0;
            sel_q        <= '0;
            bus_en_q     <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            rr_ptr_q     <= '0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            sel_q        <= sel_d;
            bus_en_q     <= bus_en_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign gnt        = gnt_q;
    assign sel        = sel_q;
    assign bus_en     = bus_en_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: default build, a short-tenure build and a 3-requester build.
module tb_bus_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  req_a, gnt_a;
    logic [63:0] din_a;
    logic [1:0]  sel_a;
    logic        en_a, vld_a;
    logic [15:0] dout_a;

    logic [3:0]  req_b, gnt_b;
    logic [63:0] din_b;
    logic [1:0]  sel_b;
    logic        en_b, vld_b;
    logic [15:0] dout_b;

    logic [2:0]  req_c, gnt_c;
    logic [47:0] din_c;
    logic [1:0]  sel_c;
    logic        en_c, vld_c;
    logic [15:0] dout_c;

    int n_chk  = 0;
    int n_pass = 0;

    bus_arbiter #(.NREQ(4), .N(16), .MAX_HOLD(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .din(din_a), .gnt(gnt_a),
        .sel(sel_a), .bus_en(en_a), .dout(dout_a), .dout_valid(vld_a)
    );

    bus_arbiter #(.NREQ(4), .N(16), .MAX_HOLD(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .din(din_b), .gnt(gnt_b),
        .sel(sel_b), .bus_en(en_b), .dout(dout_b), .dout_valid(vld_b)
    );

    bus_arbiter #(.NREQ(3), .N(16), .MAX_HOLD(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_c), .din(din_c), .gnt(gnt_c),
        .sel(sel_c), .bus_en(en_c), .dout(dout_c), .dout_valid(vld_c)
    );

    // Bus-safety invariants on every build, every cycle.
    always @(negedge clk) begin
        n_chk++;
        if (!$onehot0(gnt_a) || en_a !== (|gnt_a) || (en_a && gnt_a !== (4'b0001 << sel_a)))
            $display("FAIL inv_a gnt=%b bus_en=%b sel=%0d", gnt_a, en_a, sel_a);
        else n_pass++;
        n_chk++;
        if (!$onehot0(gnt_b) || en_b !== (|gnt_b) || (en_b && gnt_b !== (4'b0001 << sel_b)))
            $display("FAIL inv_b gnt=%b bus_en=%b sel=%0d", gnt_b, en_b, sel_b);
        else n_pass++;
        n_chk++;
        if (!$onehot0(gnt_c) || en_c !== (|gnt_c) || sel_c > 2'd2 ||
            (en_c && gnt_c !== (3'b001 << sel_c)))
            $display("FAIL inv_c gnt=%b bus_en=%b sel=%0d", gnt_c, en_c, sel_c);
        else n_pass++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req_a = '0; req_b = '0; req_c = '0;
        din_a = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA5A5};
        din_b = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        din_c = {16'h0CCC, 16'h0BBB, 16'h0AAA};
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (gnt_a !== 4'b0 || en_a !== 1'b0 || sel_a !== 2'd0 || dout_a !== 16'h0 || vld_a !== 1'b0)
            $display("FAIL reset_vals gnt=%b en=%b sel=%0d dout=%h vld=%b want all zero",
                     gnt_a, en_a, sel_a, dout_a, vld_a);
        else n_pass++;
        req_a = 4'b1111;
        tick();
        n_chk++;
        if (gnt_a !== 4'b0 || en_a !== 1'b0)
            $display("FAIL reset_hold gnt=%b en=%b want 0000/0", gnt_a, en_a);
        else n_pass++;
        req_a = '0;
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req_a = 4'b0001;
        tick();
        n_chk++;
        if (gnt_a !== 4'b0001 || sel_a !== 2'd0 || en_a !== 1'b1 || vld_a !== 1'b0)
            $display("FAIL single_grant gnt=%b sel=%0d en=%b vld=%b want 0001/0/1/0",
                     gnt_a, sel_a, en_a, vld_a);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (vld_a !== 1'b1 || dout_a !== 16'hA5A5 || gnt_a !== 4'b0001)
                $display("FAIL single_xfer%0d vld=%b dout=%h gnt=%b want 1/a5a5/0001",
                         i, vld_a, dout_a, gnt_a);
            else n_pass++;
        end
        req_a = 4'b0000;
        tick();
        n_chk++;
        if (gnt_a !== 4'b0 || en_a !== 1'b0 || vld_a !== 1'b0 || dout_a !== 16'hA5A5)
            $display("FAIL single_turn gnt=%b en=%b vld=%b dout=%h want 0000/0/0/a5a5",
                     gnt_a, en_a, vld_a, dout_a);
        else n_pass++;
        tick();
        n_chk++;
        if (gnt_a !== 4'b0 || en_a !== 1'b0 || vld_a !== 1'b0)
            $display("FAIL single_idle gnt=%b en=%b vld=%b want 0000/0/0", gnt_a, en_a, vld_a);
        else n_pass++;
    endtask

    // Each grant: two cycles owned, then one gap cycle.
    task automatic test_rotation();
        logic [3:0]  exp_g;
        logic [15:0] exp_d;
        int owner, ph;
        do_reset();
        req_b = 4'b1111;
        for (int k = 0; k < 14; k++) begin
            tick();
            owner = (k / 3) % 4;
            ph    = k % 3;
            exp_g = (ph < 2) ? (4'b0001 << owner) : 4'b0000;
            exp_d = 16'h1111 * 16'(owner + 1);
            n_chk++;
            if (gnt_b !== exp_g || (ph < 2 && sel_b !== 2'(owner)))
                $display("FAIL rot_gnt k=%0d gnt=%b sel=%0d want %b/%0d", k, gnt_b, sel_b, exp_g, owner);
            else n_pass++;
            n_chk++;
            if (vld_b !== (ph != 0) || (ph != 0 && dout_b !== exp_d))
                $display("FAIL rot_dat k=%0d vld=%b dout=%h want %b/%h", k, vld_b, dout_b, ph != 0, exp_d);
            else n_pass++;
        end
        req_b = '0;
    endtask

    task automatic test_preempt();
        logic [3:0] exp_g;
        int nv0 = 0, nv1 = 0;
        do_reset();
        req_a = 4'b0011;
        for (int e = 1; e <= 19; e++) begin
            tick();
            if (e <= 8)                   exp_g = 4'b0001;
            else if (e >= 10 && e <= 17)  exp_g = 4'b0010;
            else if (e == 19)             exp_g = 4'b0001;
            else                          exp_g = 4'b0000;
            n_chk++;
            if (gnt_a !== exp_g)
                $display("FAIL preempt_gnt e=%0d gnt=%b want %b", e, gnt_a, exp_g);
            else n_pass++;
            if (e >= 2 && e <= 9 && vld_a === 1'b1 && dout_a === 16'hA5A5) nv0++;
            if (e >= 11 && e <= 18 && vld_a === 1'b1 && dout_a === 16'hB1B1) nv1++;
            if (e == 10) begin
                n_chk++;
                if (vld_a !== 1'b0)
                    $display("FAIL preempt_gap_vld vld=%b want 0", vld_a);
                else n_pass++;
            end
        end
        n_chk++;
        if (nv0 !== 8) $display("FAIL preempt_cnt0 transfers=%0d want 8", nv0);
        else n_pass++;
        n_chk++;
        if (nv1 !== 8) $display("FAIL preempt_cnt1 transfers=%0d want 8", nv1);
        else n_pass++;
        req_a = '0;
    endtask

    task automatic test_early_release();
        do_reset();
        req_a = 4'b0100;
        tick();
        n_chk++;
        if (gnt_a !== 4'b0100 || sel_a !== 2'd2)
            $display("FAIL early_grant gnt=%b sel=%0d want 0100/2", gnt_a, sel_a);
        else n_pass++;
        tick();
        n_chk++;
        if (vld_a !== 1'b1 || dout_a !== 16'hC2C2)
            $display("FAIL early_xfer vld=%b dout=%h want 1/c2c2", vld_a, dout_a);
        else n_pass++;
        req_a = 4'b1001;
        tick();
        n_chk++;
        if (vld_a !== 1'b0 || gnt_a !== 4'b0 || en_a !== 1'b0)
            $display("FAIL early_turn vld=%b gnt=%b en=%b want 0/0000/0", vld_a, gnt_a, en_a);
        else n_pass++;
        tick();
        n_chk++;
        if (gnt_a !== 4'b1000 || sel_a !== 2'd3)
            $display("FAIL early_next gnt=%b sel=%0d want 1000/3", gnt_a, sel_a);
        else n_pass++;
        req_a = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_a = 4'b0010;
        tick();
        tick();
        n_chk++;
        if (gnt_a !== 4'b0010 || vld_a !== 1'b1 || dout_a !== 16'hB1B1)
            $display("FAIL midrst_pre gnt=%b vld=%b dout=%h want 0010/1/b1b1", gnt_a, vld_a, dout_a);
        else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        n_chk++;
        if (gnt_a !== 4'b0 || en_a !== 1'b0 || dout_a !== 16'h0 || vld_a !== 1'b0)
            $display("FAIL midrst_async gnt=%b en=%b dout=%h vld=%b want 0000/0/0000/0",
                     gnt_a, en_a, dout_a, vld_a);
        else n_pass++;
        req_a = 4'b0110;
        #2 rst_n = 1'b1;
        tick();
        n_chk++;
        if (gnt_a !== 4'b0010 || sel_a !== 2'd1)
            $display("FAIL midrst_first gnt=%b sel=%0d want 0010/1", gnt_a, sel_a);
        else n_pass++;
        req_a = '0;
    endtask

    task automatic test_nreq3();
        logic [2:0] exp_g;
        int owner, ph;
        do_reset();
        req_c = 3'b111;
        for (int k = 0; k < 12; k++) begin
            tick();
            owner = (k / 3) % 3;
            ph    = k % 3;
            exp_g = (ph < 2) ? (3'b001 << owner) : 3'b000;
            n_chk++;
            if (gnt_c !== exp_g || (ph < 2 && sel_c !== 2'(owner)))
                $display("FAIL n3_gnt k=%0d gnt=%b sel=%0d want %b/%0d", k, gnt_c, sel_c, exp_g, owner);
            else n_pass++;
        end
        req_c = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_preempt();
        test_early_release();
        test_reset_mid();
        test_nreq3();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that shares one N-bit datapath bus between NREQ requesters.
- Drives the select and enable controls of the team's mux2 tri-state mux tree, and registers the winning requester's data onto a shared output.
- Sits between the register-file/memory read ports and the shared ALU operand bus.
- Enforces a bounded tenure per grant and a one-cycle bus turnaround, so two drivers never overlap on the tri-state bus.

Parameters:
- NREQ, 4: number of requesters (2..8; need not be a power of 2).
- N, 16: data width, matching the mux2 default.
- MAX_HOLD, 8: maximum transfer cycles per grant (>=1).
- Derived: IW = $clog2(NREQ), index width; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request, level-sensitive.
- din  input  NREQ*N  requester data, flattened; requester i occupies bits [i*N +: N].
- gnt  output  NREQ  one-hot grant (all zeros when no grant).
- sel  output  IW  index of the current owner; feeds the mux tree select.
- bus_en  output  1  mux enable. When 0, the mux outputs go high-Z.
- dout  output  N  registered bus data.
- dout_valid  output  1  dout holds a transfer captured in the previous cycle.

Behaviour:
- Interface: single clock clk. Reset rst_n is asynchronous and active-low; assertion clears all state immediately, with no clock needed.
- Reset values: state=ARB_IDLE, gnt=0, sel=0, bus_en=0, dout=0, dout_valid=0, rr_ptr=0, hold_cnt=0.
- All outputs are registered.
- States: ARB_IDLE, ARB_GRANT, ARB_TURN.
- Arbitration (in IDLE and TURN):
  - Winner = first i with req[i]=1, scanning from rr_ptr upward and wrapping from NREQ-1 to 0.
  - If a winner exists: next state GRANT, gnt[w]=1, sel=w, bus_en=1, hold_cnt=0.
  - If no request: next state IDLE, with gnt, bus_en and sel unchanged at 0/0/last.
- Latency: req rising in IDLE produces gnt on the next clock edge (1 cycle).
- GRANT, owner o, req[o]=1:
  - Transfer: dout<=din[o], dout_valid<=1, hold_cnt++.
  - If hold_cnt==MAX_HOLD-1, this is the last transfer. Next state TURN, rr_ptr<=(o+1) mod NREQ.
- GRANT, req[o]=0:
  - No transfer; dout_valid<=0, dout holds its value.
  - Next state TURN, rr_ptr<=(o+1) mod NREQ.
- TURN:
  - gnt=0, bus_en=0, dout_valid=0 for exactly one cycle.
  - Arbitrates as IDLE does, so the owner-to-owner gap is exactly 1 cycle.
- dout_valid is 1 only in the cycle after a transfer cycle. dout holds its last value otherwise.
- Requests arriving mid-grant are not considered until the next arbitration. A released owner re-requesting goes to the back of the rotation.
- A requester that keeps req high beyond MAX_HOLD is pre-empted. It may win again only after every other active requester has been served.
- NREQ not a power of 2: rr_ptr and sel never exceed NREQ-1.
- Reset mid-grant: outputs drop to reset values asynchronously, and bus_en=0 releases the bus. The first arbitration after reset favours requester 0.
- Invariants: $onehot0(gnt); bus_en==|gnt; sel==index of gnt when bus_en=1.

Decomposition:
- Package bus_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_GRANT, ARB_TURN}.
  - Function for the index width, with a minimum of 1.
  - localparam of the state encoding width.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ], ptr[IW].
  - Outputs: idx[IW], any.
  - Unit-tested on its own.
- bus_arbiter instantiates rr_pick once. Its outputs connect to the mux2 enable/sel pins in the datapath top level.

Test Plan:
- Single requester: req=4'b0001 for 3 cycles, din0=16'hA5A5, then drop.
  - gnt=0001 one cycle after req.
  - dout=A5A5 with dout_valid=1 for 3 cycles.
  - TURN cycle with bus_en=0, then IDLE.
- Rotation: req=4'b1111 held, MAX_HOLD=2. Grant order 0,1,2,3,0, each grant 2 cycles, separated by one cycle with gnt=0.
- Pre-emption: req=4'b0011 held, MAX_HOLD=8.
  - Requester 0 gets exactly 8 valid transfers, then a 1-cycle gap.
  - Requester 1 is granted; requester 0 is not re-granted before requester 1 releases.
- Early release: requester 2 granted, req[2] dropped after 1 transfer.
  - dout_valid is high 1 cycle only.
  - rr_ptr=3, so with req=4'b1001 pending the next grant goes to requester 3.
- Reset mid-grant: assert rst_n=0 between clock edges while gnt=0010.
  - gnt=0, bus_en=0, dout=0, dout_valid=0 immediately.
  - After release, with req=4'b0110, requester 1 is granted first.
- NREQ=3 build: req=3'b111 held.
  - Grant order 0,1,2,0; sel never equals 3.
  - $onehot0(gnt) and the bus_en/sel assertions hold throughout.
